// File: rtl/reg_file_if.sv
// Register-file bus: writeback, read ports, scoreboard and status.
interface reg_file_if #(
  parameter int unsigned WIDTH = 16
);
  logic [15:0]      we;
  logic [WIDTH-1:0] wdata;
  logic [3:0]       ra;
  logic [3:0]       rb;
  logic             bs_v;
  logic [3:0]       bs_addr;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic             rda_busy;
  logic             rdb_busy;
  logic [15:0]      busy;
  logic             we_err;

  modport master (
    output we, wdata, ra, rb, bs_v, bs_addr,
    input  rda, rdb, rda_busy, rdb_busy, busy, we_err
  );

  modport slave (
    input  we, wdata, ra, rb, bs_v, bs_addr,
    output rda, rdb, rda_busy, rdb_busy, busy, we_err
  );
endinterface

// File: rtl/reg_file.sv
// 16-entry register file with two registered read ports and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-edge writes to the read ports.
module reg_file #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int unsigned NREG = 16;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy_q;
  logic [WIDTH-1:0] rda_q, rdb_q;
  logic             rda_busy_q, rdb_busy_q;
  logic             we_err_q;

  logic             wr_onehot_c;
  logic             wr_multi_c;
  logic [NREG-1:0]  clr_mask_c;
  logic [NREG-1:0]  set_mask_c;
  logic [NREG-1:0]  busy_nxt_c;
  logic [WIDTH-1:0] rda_nxt_c, rdb_nxt_c;
  logic             rda_busy_nxt_c, rdb_busy_nxt_c;

  // Write legality and scoreboard update; a new claim beats a completing write.
  always_comb begin
    wr_onehot_c = (bus.we != '0) && ((bus.we & (bus.we - 16'd1)) == '0);
    wr_multi_c  = (bus.we != '0) && !wr_onehot_c;
    clr_mask_c  = wr_onehot_c ? bus.we : '0;
    set_mask_c  = bus.bs_v ? (NREG'(1) << bus.bs_addr) : '0;
    busy_nxt_c  = (busy_q & ~clr_mask_c) | set_mask_c;
  end

  // Read-port next values; forwarding only ever uses a legal one-hot write.
  always_comb begin
    rda_nxt_c      = regs[bus.ra];
    rdb_nxt_c      = regs[bus.rb];
    rda_busy_nxt_c = busy_q[bus.ra];
    rdb_busy_nxt_c = busy_q[bus.rb];
`ifdef REGFILE_BYPASS_EN
    if (clr_mask_c[bus.ra]) begin
      rda_nxt_c      = bus.wdata;
      rda_busy_nxt_c = set_mask_c[bus.ra];
    end
    if (clr_mask_c[bus.rb]) begin
      rdb_nxt_c      = bus.wdata;
      rdb_busy_nxt_c = set_mask_c[bus.rb];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) regs[n] <= '0;
      busy_q     <= '0;
      rda_q      <= '0;
      rdb_q      <= '0;
      rda_busy_q <= 1'b0;
      rdb_busy_q <= 1'b0;
      we_err_q   <= 1'b0;
    end else begin
      for (int n = 0; n < NREG; n++) begin
        if (clr_mask_c[n]) regs[n] <= bus.wdata;
      end
      busy_q     <= busy_nxt_c;
      rda_q      <= rda_nxt_c;
      rdb_q      <= rdb_nxt_c;
      rda_busy_q <= rda_busy_nxt_c;
      rdb_busy_q <= rdb_busy_nxt_c;
      if (wr_multi_c) we_err_q <= 1'b1;
    end
  end

  assign bus.rda      = rda_q;
  assign bus.rdb      = rdb_q;
  assign bus.rda_busy = rda_busy_q;
  assign bus.rdb_busy = rdb_busy_q;
  assign bus.busy     = busy_q;
  assign bus.we_err   = we_err_q;
endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file against an array-based behavioural model.
module tb_reg_file;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst;
  reg_file_if #(.WIDTH(WIDTH)) bus ();

  reg_file #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [WIDTH-1:0] mem [16];
  logic [15:0]      m_busy;
  logic             m_err;
  logic [WIDTH-1:0] e_rda, e_rdb;
  logic             e_rda_b, e_rdb_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reads see state before the edge, then writes/scoreboard apply.
  always @(posedge clk) begin
    int idx;
    bit legal;
    logic [15:0] nb;
    if (rst) begin
      for (int n = 0; n < 16; n++) mem[n] = '0;
      m_busy = '0; m_err = 1'b0;
      e_rda = '0; e_rdb = '0; e_rda_b = 1'b0; e_rdb_b = 1'b0;
    end else begin
      legal = ($countones(bus.we) == 1);
      idx = -1;
      for (int n = 0; n < 16; n++) if (legal && bus.we[n]) idx = n;
      e_rda   = mem[bus.ra];
      e_rdb   = mem[bus.rb];
      e_rda_b = m_busy[bus.ra];
      e_rdb_b = m_busy[bus.rb];
      nb = m_busy;
      if (idx >= 0) nb[idx] = 1'b0;
      if (bus.bs_v) nb[bus.bs_addr] = 1'b1;
`ifdef REGFILE_BYPASS_EN
      if (idx == int'(bus.ra)) begin
        e_rda = bus.wdata; e_rda_b = bus.bs_v && (bus.bs_addr == bus.ra);
      end
      if (idx == int'(bus.rb)) begin
        e_rdb = bus.wdata; e_rdb_b = bus.bs_v && (bus.bs_addr == bus.rb);
      end
`endif
      if (idx >= 0) mem[idx] = bus.wdata;
      m_busy = nb;
      if ($countones(bus.we) > 1) m_err = 1'b1;
    end
  end

  // Compare process on the inactive edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("rda", 32'(bus.rda), 32'(e_rda));
      check("rdb", 32'(bus.rdb), 32'(e_rdb));
      check("rda_busy", 32'(bus.rda_busy), 32'(e_rda_b));
      check("rdb_busy", 32'(bus.rdb_busy), 32'(e_rdb_b));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("we_err", 32'(bus.we_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = '0; bus.bs_v = 1'b0;
  endtask

  logic [15:0] exp_rw;
  logic [15:0] r;

  initial begin
    rst = 1'b1;
    bus.we = '0; bus.wdata = '0; bus.ra = '0; bus.rb = '0;
    bus.bs_v = 1'b0; bus.bs_addr = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset then read all
    for (int i = 0; i < 16; i++) begin
      bus.ra = 4'(i); bus.rb = 4'(15 - i);
      cyc();
      check("sweep_rda", 32'(bus.rda), 32'h0);
      check("sweep_rdb", 32'(bus.rdb), 32'h0);
    end
    check("sweep_busy", 32'(bus.busy), 32'h0);
    check("sweep_err", 32'(bus.we_err), 32'h0);

    // Write / read back
    bus.we = 16'h0020; bus.wdata = 16'hA5A5;
    cyc();
    idle(); bus.ra = 4'd5; bus.rb = 4'd4;
    cyc();
    check("wr_r5", 32'(bus.rda), 32'hA5A5);
    check("wr_r4", 32'(bus.rdb), 32'h0);

    // Same-cycle read during write
    bus.we = 16'h0008; bus.wdata = 16'h1111;
    cyc();
    bus.we = 16'h0008; bus.wdata = 16'h2222; bus.ra = 4'd3;
    cyc();
`ifdef REGFILE_BYPASS_EN
    exp_rw = 16'h2222;
`else
    exp_rw = 16'h1111;
`endif
    check("rdw_r3", 32'(bus.rda), 32'(exp_rw));
    idle();
    cyc();
    check("rdw_r3_after", 32'(bus.rda), 32'h2222);

    // Scoreboard
    bus.bs_v = 1'b1; bus.bs_addr = 4'd7;
    cyc();
    check("sb_set", 32'(bus.busy), 32'h0080);
    idle(); bus.we = 16'h0080; bus.wdata = 16'h0707;
    cyc();
    check("sb_clr", 32'(bus.busy), 32'h0000);
    bus.we = 16'h0080; bus.bs_v = 1'b1; bus.bs_addr = 4'd7;
    cyc();
    check("sb_set_wins", 32'(bus.busy), 32'h0080);
    idle();

    // Illegal enable
    bus.we = 16'h0011; bus.wdata = 16'hFFFF;
    cyc();
    check("err_rise", 32'(bus.we_err), 32'h1);
    idle(); bus.ra = 4'd0; bus.rb = 4'd4;
    cyc();
    check("err_r0", 32'(bus.rda), 32'h0);
    check("err_r4", 32'(bus.rdb), 32'h0);
    repeat (10) cyc();
    check("err_sticky", 32'(bus.we_err), 32'h1);
    bus.we = 16'h0002; bus.wdata = 16'h1234;
    cyc();
    idle(); bus.ra = 4'd1;
    cyc();
    check("err_then_wr", 32'(bus.rda), 32'h1234);

    // Reset mid-operation
    bus.we = 16'h0200; bus.wdata = 16'h5555;
    cyc();
    bus.we = 16'h0200; bus.wdata = 16'h7777; bus.bs_v = 1'b1; bus.bs_addr = 4'd9;
    bus.ra = 4'd9; bus.rb = 4'd9; rst = 1'b1;
    cyc();
    check("rst_rda", 32'(bus.rda), 32'h0);
    check("rst_rdb", 32'(bus.rdb), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.we_err), 32'h0);
    rst = 1'b0; idle();
    cyc();
    check("rst_r9", 32'(bus.rda), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: bus.we = '0;
        9: begin
          bus.we = r;
          if ($countones(r) < 2) bus.we = r | 16'h8001;
        end
        default: bus.we = 16'(1) << $urandom_range(0, 15);
      endcase
      bus.wdata   = 16'($urandom);
      bus.ra      = 4'($urandom_range(0, 15));
      bus.rb      = ($urandom_range(0, 3) == 0) ? bus.ra : 4'($urandom_range(0, 15));
      bus.bs_v    = 1'($urandom_range(0, 2) == 0);
      bus.bs_addr = ($urandom_range(0, 3) == 0) ? bus.ra : 4'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; idle();
    cyc();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
